// File: rtl/bus_dma_arbiter_if.sv
// CPU/DMA/memory bus bundle for bus_dma_arbiter; the arbiter takes the slave view.
// Pure wiring, no latency of its own.
// Backpressure is carried by cpu_rdy (core stall) and dma_gnt (DMA ownership).
interface bus_dma_arbiter_if;
   logic [15:0] cpu_ad;
   logic [7:0]  cpu_do;
   logic        cpu_we;
   logic        cpu_sync;
   logic        cpu_rdy;
   logic        dma_req;
   logic [15:0] dma_ad;
   logic [7:0]  dma_do;
   logic        dma_we;
   logic        dma_gnt;
   logic [15:0] mem_ad;
   logic [7:0]  mem_do;
   logic        mem_we;

   // Environment side: core, DMA master and memory decode.
   modport master (
      output cpu_ad, cpu_do, cpu_we, cpu_sync, dma_req, dma_ad, dma_do, dma_we,
      input  cpu_rdy, dma_gnt, mem_ad, mem_do, mem_we
   );

   // Arbiter side.
   modport slave (
      input  cpu_ad, cpu_do, cpu_we, cpu_sync, dma_req, dma_ad, dma_do, dma_we,
      output cpu_rdy, dma_gnt, mem_ad, mem_do, mem_we
   );
endinterface

// File: rtl/bus_dma_arbiter.sv
// Shares the 65C02 memory bus with one DMA master, stalling the core only on read cycles.
// Grant one cycle after a stealable read with dma_req; bus mux is combinational.
// Core held via cpu_rdy while DMA owns the bus; bursts bounded by MAX_BURST, then CPU_MIN cooldown.
// Optional: define SYNC_ALIGN_EN to steal only on opcode-fetch (cpu_sync) cycles.
module bus_dma_arbiter #(
   parameter int MAX_BURST = 16,
   parameter int CPU_MIN   = 4
) (
   input  logic clk,
   input  logic RST_N,
   bus_dma_arbiter_if.slave bus
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int CW = (CPU_MIN > 0) ? $clog2(CPU_MIN + 1) : 1;

   typedef enum logic {ST_CPU = 1'b0, ST_DMA = 1'b1} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [BW-1:0] r_beats;
   logic [CW-1:0] r_cool;
   logic          w_sync_ok;
   logic          w_take;
   logic          w_release;
   logic          w_last_beat;

`ifdef SYNC_ALIGN_EN
   // Only instruction boundaries may be stolen; an opcode fetch is always a read.
   assign w_sync_ok = bus.cpu_sync;
`else
   assign w_sync_ok = 1'b1;
`endif

   assign w_last_beat = (r_beats == BW'(MAX_BURST - 1));

   // The core's read in the take cycle still reaches memory; it is repeated once RDY returns.
   assign w_take = (r_state == ST_CPU) & bus.dma_req & ~bus.cpu_we & (r_cool == '0)
                   & RST_N & w_sync_ok;

   // Release on an idle DMA cycle, or after performing the last permitted beat.
   assign w_release = (r_state == ST_DMA) & (~bus.dma_req | w_last_beat);

   // State register; reset returns the bus to the core immediately.
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) r_state <= ST_CPU;
      else        r_state <= w_next;
   end

   // Next state and bus mux; grant is a decode of the registered state.
   always_comb begin
      w_next       = r_state;
      bus.cpu_rdy  = 1'b0;
      bus.dma_gnt  = 1'b0;
      bus.mem_ad   = bus.cpu_ad;
      bus.mem_do   = bus.cpu_do;
      bus.mem_we   = bus.cpu_we;
      case (r_state)
         ST_CPU: begin
            bus.cpu_rdy = ~w_take;
            if (w_take) w_next = ST_DMA;
         end
         ST_DMA: begin
            bus.dma_gnt = 1'b1;
            bus.mem_ad  = bus.dma_ad;
            bus.mem_do  = bus.dma_do;
            // No write on the cycle the DMA master lets go of the bus.
            bus.mem_we  = bus.dma_we & bus.dma_req;
            if (w_release) w_next = ST_CPU;
         end
         default: w_next = ST_CPU;
      endcase
   end

   // Beat counter: cleared on grant, advanced on each DMA beat.
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N)                                            r_beats <= '0;
      else if (w_take)                                       r_beats <= '0;
      else if ((r_state == ST_DMA) && bus.dma_req && !w_last_beat) r_beats <= r_beats + 1'b1;
   end

   // Cooldown: guaranteed CPU window after each release before the next grant.
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N)                                      r_cool <= '0;
      else if (w_release)                              r_cool <= CW'(CPU_MIN);
      else if ((r_state == ST_CPU) && (r_cool != '0))  r_cool <= r_cool - 1'b1;
   end

endmodule

// File: tb/tb_bus_dma_arbiter.sv
// Self-checking bench for bus_dma_arbiter: directed scenarios followed by random traffic,
// all outputs compared every cycle against a cycle-level ownership model.
// Honours SYNC_ALIGN_EN when defined for the build.
module tb_bus_dma_arbiter;
   localparam int MAX_BURST = 16;
   localparam int CPU_MIN   = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bus_dma_arbiter_if bus ();

   bus_dma_arbiter #(.MAX_BURST(MAX_BURST), .CPU_MIN(CPU_MIN)) dut (
      .clk   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Model: who owns the bus, beats already done in this grant, CPU cycles still reserved.
   bit m_dma_owns;
   int m_beats_done;
   int m_cpu_reserved;

   function automatic bit m_take();
      bit t;
      t = !m_dma_owns && bus.dma_req && !bus.cpu_we && (m_cpu_reserved == 0) && (rst_n === 1'b1);
`ifdef SYNC_ALIGN_EN
      t = t && bus.cpu_sync;
`endif
      return t;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [15:0] e_ad;
      logic [7:0]  e_do;
      logic        e_we;
      e_ad = m_dma_owns ? bus.dma_ad : bus.cpu_ad;
      e_do = m_dma_owns ? bus.dma_do : bus.cpu_do;
      e_we = m_dma_owns ? (bus.dma_we & bus.dma_req) : bus.cpu_we;
      chk("cpu_rdy", 32'(bus.cpu_rdy), 32'(!m_dma_owns && !m_take()));
      chk("dma_gnt", 32'(bus.dma_gnt), 32'(m_dma_owns));
      chk("mem_ad",  32'(bus.mem_ad),  32'(e_ad));
      chk("mem_do",  32'(bus.mem_do),  32'(e_do));
      chk("mem_we",  32'(bus.mem_we),  32'(e_we));
   endtask

   task automatic model_reset();
      m_dma_owns     = 1'b0;
      m_beats_done   = 0;
      m_cpu_reserved = 0;
   endtask

   task automatic model_clock();
      if (rst_n !== 1'b1) return;
      if (m_dma_owns) begin
         if (!bus.dma_req) begin
            m_dma_owns = 1'b0;
            m_cpu_reserved = CPU_MIN;
         end else begin
            m_beats_done++;
            if (m_beats_done == MAX_BURST) begin
               m_dma_owns = 1'b0;
               m_cpu_reserved = CPU_MIN;
            end
         end
      end else if (m_take()) begin
         m_dma_owns = 1'b1;
         m_beats_done = 0;
      end else if (m_cpu_reserved > 0) begin
         m_cpu_reserved--;
      end
   endtask

   task automatic set_rst(input bit v);
      rst_n = v;
      if (!v) model_reset();
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic finish_cyc();
      check_all();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic cycles(input int n);
      for (int k = 0; k < n; k++) begin
         to_neg();
         finish_cyc();
      end
   endtask

   int run, max_run, gap, min_gap;
   bit seen_burst;

   initial begin
      model_reset();
      rst_n        = 1'b0;
      bus.cpu_ad   = 16'h1234;
      bus.cpu_do   = 8'h5A;
      bus.cpu_we   = 1'b0;
      bus.cpu_sync = 1'b1;
      bus.dma_req  = 1'b1;
      bus.dma_ad   = 16'hC000;
      bus.dma_do   = 8'hA5;
      bus.dma_we   = 1'b0;

      // Reset held with dma_req pending: core keeps the bus.
      for (int k = 0; k < 3; k++) begin
         to_neg();
         chk("t1_rdy",    32'(bus.cpu_rdy), 32'd1);
         chk("t1_gnt",    32'(bus.dma_gnt), 32'd0);
         chk("t1_mem_ad", 32'(bus.mem_ad),  32'h1234);
         finish_cyc();
      end

      // Request during a write is ignored, taken on the following read.
      bus.cpu_we = 1'b1;
      set_rst(1'b1);
      to_neg();
      chk("t2_c1_rdy", 32'(bus.cpu_rdy), 32'd1);
      finish_cyc();
      bus.cpu_we = 1'b0;
      to_neg();
      chk("t2_c2_rdy", 32'(bus.cpu_rdy), 32'd0);
      finish_cyc();
      to_neg();
      chk("t2_c3_gnt",    32'(bus.dma_gnt), 32'd1);
      chk("t2_c3_mem_ad", 32'(bus.mem_ad),  32'hC000);
      finish_cyc();

      // Sustained request: bursts of MAX_BURST separated by CPU_MIN free cycles.
      bus.dma_req = 1'b0;
      cycles(12);
      bus.dma_req = 1'b1;
      run = 0; max_run = 0; gap = 0; min_gap = 1000; seen_burst = 1'b0;
      for (int k = 0; k < 60; k++) begin
         to_neg();
         if (bus.dma_gnt) begin
            run++;
            seen_burst = 1'b1;
            gap = 0;
         end else begin
            if (run > max_run) max_run = run;
            run = 0;
            if (bus.cpu_rdy) gap++;
            else if (seen_burst && gap < min_gap) min_gap = gap;
         end
         finish_cyc();
      end
      chk("t3_burst_len", 32'(max_run), 32'(MAX_BURST));
      chk("t3_cpu_gap",   32'(min_gap), 32'(CPU_MIN));

      // Early release: no write on the cycle dma_req drops.
      bus.dma_req = 1'b0;
      cycles(12);
      bus.dma_we  = 1'b1;
      bus.dma_req = 1'b1;
      cycles(1);
      for (int k = 0; k < 3; k++) begin
         to_neg();
         chk("t4_beat_we", 32'(bus.mem_we), 32'd1);
         finish_cyc();
      end
      bus.dma_req = 1'b0;
      to_neg();
      chk("t4_drop_we",  32'(bus.mem_we),  32'd0);
      chk("t4_drop_gnt", 32'(bus.dma_gnt), 32'd1);
      finish_cyc();
      to_neg();
      chk("t4_after_gnt", 32'(bus.dma_gnt), 32'd0);
      chk("t4_after_rdy", 32'(bus.cpu_rdy), 32'd1);
      finish_cyc();

      // Reset mid-burst takes effect without a clock edge.
      cycles(12);
      bus.dma_req = 1'b1;
      cycles(5);
      bus.cpu_ad = 16'h2222;
      bus.cpu_we = 1'b1;
      set_rst(1'b0);
      #1;
      chk("t5_gnt",    32'(bus.dma_gnt), 32'd0);
      chk("t5_rdy",    32'(bus.cpu_rdy), 32'd1);
      chk("t5_mem_ad", 32'(bus.mem_ad),  32'h2222);
      chk("t5_mem_we", 32'(bus.mem_we),  32'd1);
      to_neg();
      finish_cyc();
      bus.cpu_we = 1'b0;
      set_rst(1'b1);
      to_neg();
      chk("t5_post_gnt", 32'(bus.dma_gnt), 32'd0);
      finish_cyc();
      to_neg();
      chk("t5_regrant", 32'(bus.dma_gnt), 32'd1);
      finish_cyc();

`ifdef SYNC_ALIGN_EN
      // Steal only at an opcode fetch.
      bus.dma_req = 1'b0;
      cycles(25);
      bus.cpu_sync = 1'b0;
      bus.dma_req  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         to_neg();
         chk("t6_nosync_rdy", 32'(bus.cpu_rdy), 32'd1);
         finish_cyc();
      end
      bus.cpu_sync = 1'b1;
      to_neg();
      chk("t6_sync_rdy", 32'(bus.cpu_rdy), 32'd0);
      finish_cyc();
      to_neg();
      chk("t6_gnt", 32'(bus.dma_gnt), 32'd1);
      finish_cyc();
`endif

      // Random traffic against the model.
      for (int k = 0; k < 800; k++) begin
         bus.cpu_ad   = 16'($urandom);
         bus.cpu_do   = 8'($urandom);
         bus.cpu_we   = ($urandom_range(0, 3) == 0);
         bus.cpu_sync = $urandom_range(0, 1) == 1;
         bus.dma_req  = ($urandom_range(0, 9) < 8);
         bus.dma_ad   = 16'($urandom);
         bus.dma_do   = 8'($urandom);
         bus.dma_we   = $urandom_range(0, 1) == 1;
         set_rst($urandom_range(0, 99) != 0);
         to_neg();
         finish_cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
